// File: rtl/sport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sport_pkg
//  Description : Shared constants and types for the SPORT0 clock/frame-sync
//                generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sport_pkg;

    localparam int CW  = 16;
    localparam int WCW = 5;

    localparam logic c_sclk_idle = 1'b0;
    // Frame-sync idle level before the INVxFS polarity is applied
    localparam logic c_fs_idle   = 1'b0;

    typedef enum logic {
        FSW_NORMAL = 1'b0,
        FSW_ALT    = 1'b1
    } fsw_mode_e;

endpackage
`default_nettype wire

// File: rtl/sport0_clkfs_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sport0_clkfs_gen_if
//  Description : Control-register and serialiser-facing signals of the SPORT0
//                clock/frame-sync generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sport0_clkfs_gen_if #(
    parameter int CW = sport_pkg::CW
);
    import sport_pkg::*;

    logic           SPEN;
    logic [CW-1:0]  SCLKDIV;
    logic [CW-1:0]  FSDIV;
    logic           SCLKDIV_we;
    logic           FSDIV_we;
    logic           SCTL_we;
    logic           ISCLK;
    logic           ITFS;
    logic           IRFS;
    logic           FSW;
    logic           INVTFS;
    logic           INVRFS;
    logic [WCW-1:0] SLEN;
    logic           TX_PEND;

    logic           SCLK_int;
    logic           SCLK_rise;
    logic           SCLK_fall;
    logic           TFS_int;
    logic           RFS_int;
    logic           TFS_ack;

    modport master (
        output SPEN, SCLKDIV, FSDIV, SCLKDIV_we, FSDIV_we, SCTL_we,
               ISCLK, ITFS, IRFS, FSW, INVTFS, INVRFS, SLEN, TX_PEND,
        input  SCLK_int, SCLK_rise, SCLK_fall, TFS_int, RFS_int, TFS_ack
    );

    modport slave (
        input  SPEN, SCLKDIV, FSDIV, SCLKDIV_we, FSDIV_we, SCTL_we,
               ISCLK, ITFS, IRFS, FSW, INVTFS, INVRFS, SLEN, TX_PEND,
        output SCLK_int, SCLK_rise, SCLK_fall, TFS_int, RFS_int, TFS_ack
    );

endinterface
`default_nettype wire

// File: rtl/sport_dncnt.sv
`default_nettype none
// ============================================================================
//  Module      : sport_dncnt
//  Description : Loadable down-counter with advance enable, restart load and
//                zero flag; reloads on advance from zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sport_dncnt #(
    parameter int CW = sport_pkg::CW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_en,
    input  wire logic          i_restart,
    input  wire logic [CW-1:0] i_restart_val,
    input  wire logic [CW-1:0] i_reload_val,
    output logic               o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= i_restart_val;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? i_reload_val : r_cnt - CW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sport0_clkfs_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sport0_clkfs_gen
//  Description : SPORT0 internal serial-clock divider and TFS/RFS frame-sync
//                generator with transmit-start handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sport0_clkfs_gen #(
    parameter int CW = sport_pkg::CW
) (
    input  wire logic         DSPCLK,
    input  wire logic         RSTn,
    sport0_clkfs_gen_if.slave bus
);
    import sport_pkg::*;

    logic           w_en;
    logic           w_restart;
    logic           w_hold;
    logic           w_dzero;
    logic           w_fzero;
    logic           w_rise;
    logic           w_fall;
    logic           w_bound;
    logic           w_tfs_go;
    logic           w_rfs_go;
    logic [WCW-1:0] w_len;

    logic           r_spen_d;
    logic           r_sclk;
    logic           r_rise;
    logic           r_fall;
    logic           r_ack;
    logic           r_tact;
    logic           r_ract;
    logic [WCW-1:0] r_twcnt;
    logic [WCW-1:0] r_rwcnt;

    assign w_en      = bus.SPEN & bus.ISCLK;
    assign w_restart = bus.SCLKDIV_we | bus.FSDIV_we | bus.SCTL_we | (r_spen_d & ~bus.SPEN);
    // Disabled and restarting both park every counter at its load value
    assign w_hold    = ~w_en | w_restart;

    assign w_rise    = ~w_hold & w_dzero & ~r_sclk;
    assign w_fall    = ~w_hold & w_dzero &  r_sclk;
    assign w_bound   = w_rise & w_fzero;
    assign w_tfs_go  = w_bound & bus.ITFS & bus.TX_PEND;
    assign w_rfs_go  = w_bound & bus.IRFS;
    assign w_len     = (fsw_mode_e'(bus.FSW) == FSW_ALT) ? bus.SLEN : '0;

    sport_dncnt #(.CW(CW)) u_dcnt (
        .clk           (DSPCLK),
        .rst_n         (RSTn),
        .i_en          (1'b1),
        .i_restart     (w_hold),
        .i_restart_val (bus.SCLKDIV),
        .i_reload_val  (bus.SCLKDIV),
        .o_zero        (w_dzero)
    );

    // Parked at zero so the first SCLK rise after enable/restart is a boundary
    sport_dncnt #(.CW(CW)) u_fcnt (
        .clk           (DSPCLK),
        .rst_n         (RSTn),
        .i_en          (w_rise),
        .i_restart     (w_hold),
        .i_restart_val ('0),
        .i_reload_val  (bus.FSDIV),
        .o_zero        (w_fzero)
    );

    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            r_spen_d <= 1'b0;
            r_sclk   <= c_sclk_idle;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_ack    <= 1'b0;
            r_tact   <= c_fs_idle;
            r_ract   <= c_fs_idle;
            r_twcnt  <= '0;
            r_rwcnt  <= '0;
        end else begin
            r_spen_d <= bus.SPEN;
            if (w_hold) begin
                r_sclk  <= c_sclk_idle;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_ack   <= 1'b0;
                r_tact  <= c_fs_idle;
                r_ract  <= c_fs_idle;
                r_twcnt <= '0;
                r_rwcnt <= '0;
            end else begin
                r_sclk <= r_sclk ^ w_dzero;
                r_rise <= w_rise;
                r_fall <= w_fall;
                r_ack  <= w_tfs_go;
                // A boundary always re-arms the width, truncating an overlong pulse
                if (w_bound) begin
                    r_tact  <= w_tfs_go;
                    r_twcnt <= w_tfs_go ? w_len : '0;
                    r_ract  <= w_rfs_go;
                    r_rwcnt <= w_rfs_go ? w_len : '0;
                end else if (w_rise) begin
                    if (r_twcnt == '0) r_tact  <= c_fs_idle;
                    else               r_twcnt <= r_twcnt - WCW'(1);
                    if (r_rwcnt == '0) r_ract  <= c_fs_idle;
                    else               r_rwcnt <= r_rwcnt - WCW'(1);
                end
            end
        end
    end

    assign bus.SCLK_int  = r_sclk;
    assign bus.SCLK_rise = r_rise;
    assign bus.SCLK_fall = r_fall;
    assign bus.TFS_ack   = r_ack;
    assign bus.TFS_int   = (r_tact & bus.ITFS) ^ bus.INVTFS;
    assign bus.RFS_int   = (r_ract & bus.IRFS) ^ bus.INVRFS;

endmodule
`default_nettype wire

// File: tb/tb_sport0_clkfs_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sport0_clkfs_gen
//  Description : Self-checking bench for sport0_clkfs_gen against a
//                cycle-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sport0_clkfs_gen;

    logic DSPCLK = 1'b0;
    logic RSTn   = 1'b1;

    always #5 DSPCLK = ~DSPCLK;

    sport0_clkfs_gen_if #(.CW(16)) bus ();

    sport0_clkfs_gen #(.CW(16)) dut (
        .DSPCLK (DSPCLK),
        .RSTn   (RSTn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: k = enabled DSPCLK edges since the last enable/restart
    int k;
    int D;
    int F;
    int W;
    bit frame_tx;
    bit tx_drv;
    bit last_ack;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b k=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic check_rst();
        check("rst_sclk", bus.SCLK_int,  1'b0);
        check("rst_rise", bus.SCLK_rise, 1'b0);
        check("rst_fall", bus.SCLK_fall, 1'b0);
        check("rst_ack",  bus.TFS_ack,   1'b0);
        check("rst_tfs",  bus.TFS_int,   bus.INVTFS);
        check("rst_rfs",  bus.RFS_int,   bus.INVRFS);
    endtask

    task automatic predict_check();
        int P, q, m, pos;
        bit on_edge, e_sclk, e_rise, e_fall, bnd, inwin;
        P       = D + 1;
        q       = k / P;
        on_edge = (k % P) == 0;
        e_sclk  = (q % 2) == 1;
        e_rise  = (k > 0) && on_edge &&  e_sclk;
        e_fall  = (k > 0) && on_edge && !e_sclk;
        bnd     = 1'b0;
        inwin   = 1'b0;
        if (q >= 1) begin
            m     = (q - 1) / 2;
            pos   = m % (F + 1);
            bnd   = e_rise && (pos == 0);
            inwin = pos < W;
        end
        if (k == 0) frame_tx = 1'b0;
        if (bnd)    frame_tx = tx_drv && bus.ITFS;
        last_ack = bnd && frame_tx;
        check("sclk", bus.SCLK_int,  e_sclk);
        check("rise", bus.SCLK_rise, e_rise);
        check("fall", bus.SCLK_fall, e_fall);
        check("ack",  bus.TFS_ack,   last_ack);
        check("tfs",  bus.TFS_int,   (inwin && frame_tx && bus.ITFS) ^ bus.INVTFS);
        check("rfs",  bus.RFS_int,   (inwin && bus.IRFS) ^ bus.INVRFS);
    endtask

    // wsel: 0 none, 1 SCTL_we, 2 FSDIV_we, 3 SCLKDIV_we
    task automatic step(input int wsel);
        bit hold;
        bus.SCTL_we    = (wsel == 1);
        bus.FSDIV_we   = (wsel == 2);
        bus.SCLKDIV_we = (wsel == 3);
        tx_drv = bus.TX_PEND;
        hold   = !(bus.SPEN && bus.ISCLK) || (wsel != 0);
        @(posedge DSPCLK);
        #1;
        bus.SCTL_we    = 1'b0;
        bus.FSDIV_we   = 1'b0;
        bus.SCLKDIV_we = 1'b0;
        k = hold ? 0 : k + 1;
        predict_check();
    endtask

    task automatic apply_setup(input int d, input int f, input int fsw, input int slen,
                               input int itfs, input int irfs, input int invt, input int invr);
        bus.SCLKDIV = 16'(d);
        bus.FSDIV   = 16'(f);
        bus.FSW     = (fsw != 0);
        bus.SLEN    = 5'(slen);
        bus.ITFS    = (itfs != 0);
        bus.IRFS    = (irfs != 0);
        bus.INVTFS  = (invt != 0);
        bus.INVRFS  = (invr != 0);
        bus.SPEN    = 1'b1;
        bus.ISCLK   = 1'b1;
        D = d;
        F = f;
        W = (fsw != 0) ? slen + 1 : 1;
        step(1);
    endtask

    // txmode: 0 never pending, 1 always pending, 2 random, 3 raised at cycle 40
    task automatic run(input int n, input int txmode);
        for (int i = 0; i < n; i++) begin
            case (txmode)
                0: bus.TX_PEND = 1'b0;
                1: bus.TX_PEND = 1'b1;
                2: if ($urandom_range(0, 7) == 0) bus.TX_PEND = ~bus.TX_PEND;
                default: if (i == 40) bus.TX_PEND = 1'b1;
            endcase
            if (last_ack && txmode != 1) bus.TX_PEND = 1'b0;
            step(0);
        end
    endtask

    initial begin
        bus.SPEN = 1'b0; bus.SCLKDIV = '0; bus.FSDIV = '0;
        bus.SCLKDIV_we = 1'b0; bus.FSDIV_we = 1'b0; bus.SCTL_we = 1'b0;
        bus.ISCLK = 1'b0; bus.ITFS = 1'b0; bus.IRFS = 1'b0; bus.FSW = 1'b0;
        bus.INVTFS = 1'b0; bus.INVRFS = 1'b0; bus.SLEN = '0; bus.TX_PEND = 1'b0;
        k = 0; D = 0; F = 0; W = 1; frame_tx = 1'b0; tx_drv = 1'b0; last_ack = 1'b0;

        #2 RSTn = 1'b0;
        #1 check_rst();
        repeat (2) @(posedge DSPCLK);
        @(negedge DSPCLK) RSTn = 1'b1;
        repeat (3) step(0);

        // Basic divider, divide-by-8
        apply_setup(3, 7, 0, 0, 0, 1, 0, 0);
        run(40, 0);
        // DSPCLK/2 clock, RFS every 16 DSPCLK
        apply_setup(0, 7, 0, 0, 0, 1, 0, 0);
        run(48, 0);
        // Alternate framing TFS with TX_PEND raised mid-frame
        apply_setup(0, 31, 1, 15, 1, 0, 0, 0);
        run(200, 3);
        // Truncated alternate framing with inverted RFS
        apply_setup(0, 9, 1, 15, 0, 1, 0, 1);
        run(60, 0);
        // FSDIV_we during a pulse, on a divider terminal count
        apply_setup(2, 3, 0, 0, 1, 1, 0, 0);
        bus.TX_PEND = 1'b1;
        run(5, 1);
        step(2);
        run(30, 1);
        // Disable via ISCLK, then re-enable without a write strobe
        bus.ISCLK = 1'b0;
        run(10, 2);
        bus.ISCLK = 1'b1;
        run(30, 2);
        // Asynchronous reset mid-frame
        apply_setup(1, 5, 1, 2, 1, 1, 1, 1);
        run(23, 1);
        @(negedge DSPCLK) RSTn = 1'b0;
        #1 check_rst();
        @(posedge DSPCLK);
        #1 check_rst();
        @(negedge DSPCLK) RSTn = 1'b1;
        k = D;
        frame_tx = 1'b0;
        run(60, 1);

        for (int s = 0; s < 10; s++) begin
            apply_setup($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 1),
                        $urandom_range(0, 12), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 1));
            run(120, $urandom_range(0, 2));
            step($urandom_range(1, 3));
            run(40, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
